quad_encoder_bank: RTL and testbench

- Parametrised multi-channel rotary-encoder front end: N independent channels, each with a debouncer, a quadrature decoder and an up/down value register.
- Adds to the single-channel debounce+encoder pair: selectable x1/x4 decoding, configurable step size, wrap or saturate arithmetic, a synchronous preload port, per-channel change strobes and a sticky illegal-transition flag.
- Sits between the raw encoder pins and the PWM/colour-mixing logic (default 3 channels for R/G/B).

---
 rtl/quad_encoder_bank.sv | 132 +++++++++++++
 tb/tb_quad_encoder_bank.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_bank.sv
// Multi-channel rotary encoder front end: per-channel debounce, x1/x4 quadrature
// decode and an up/down value register with wrap or saturate arithmetic.
module quad_encoder_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int MODE     = 0,
    parameter int STEP     = 1,
    parameter int SATURATE = 0,
    parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic                      load_en,
    input  logic [CH_BITS-1:0]        load_ch,
    input  logic [WIDTH-1:0]          load_val,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS-1:0]       err
);

    localparam logic [WIDTH:0] MAX_W  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [HIST_LEN-1:0] hist_a;
        logic [HIST_LEN-1:0] hist_b;
        logic [HIST_LEN-1:0] hist_a_next;
        logic [HIST_LEN-1:0] hist_b_next;
        logic                a_db;
        logic                b_db;
        logic [1:0]          prev;
        logic [1:0]          cur;
        logic                inc;
        logic                dec;
        logic                illegal;
        logic                load_hit;
        logic [WIDTH:0]      sum;
        logic [WIDTH-1:0]    val;
        logic [WIDTH-1:0]    val_next;
        logic                chg;
        logic                er;

        assign hist_a_next = {hist_a[HIST_LEN-2:0], a[i]};
        assign hist_b_next = {hist_b[HIST_LEN-2:0], b[i]};
        assign cur         = {a_db, b_db};
        assign load_hit    = load_en && (load_ch == CH_BITS'(i));

        // The debounced level follows the history including the sample taken on
        // this edge, so a held level appears after exactly HIST_LEN samples.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hist_a <= '0;
                hist_b <= '0;
                a_db   <= 1'b0;
                b_db   <= 1'b0;
                prev   <= 2'b00;
            end else begin
                hist_a <= hist_a_next;
                hist_b <= hist_b_next;
                if (&hist_a_next)
                    a_db <= 1'b1;
                else if (~|hist_a_next)
                    a_db <= 1'b0;
                if (&hist_b_next)
                    b_db <= 1'b1;
                else if (~|hist_b_next)
                    b_db <= 1'b0;
                prev <= cur;
            end
        end

        always_comb begin
            inc     = 1'b0;
            dec     = 1'b0;
            illegal = ((prev ^ cur) == 2'b11);
            if (MODE == 1) begin
                case ({prev, cur})
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: inc = 1'b1;
                    4'b1000, 4'b1110, 4'b0111, 4'b0001: dec = 1'b1;
                    default: ;
                endcase
            end else if (!prev[1] && cur[1] && (prev[0] == cur[0])) begin
                // Rising A with B steady: B low means forward rotation.
                inc = !cur[0];
                dec = cur[0];
            end
        end

        always_comb begin
            sum      = '0;
            val_next = val;
            if (inc) begin
                sum = {1'b0, val} + STEP_W;
                if ((SATURATE != 0) && (sum > MAX_W))
                    val_next = MAX_W[WIDTH-1:0];
                else
                    val_next = sum[WIDTH-1:0];
            end else if (dec) begin
                if ((SATURATE != 0) && ({1'b0, val} < STEP_W))
                    val_next = '0;
                else
                    val_next = val - STEP_W[WIDTH-1:0];
            end
        end

        // A preload overrides any count landing on the same edge and clears err.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                val <= '0;
                chg <= 1'b0;
                er  <= 1'b0;
            end else if (load_hit) begin
                val <= load_val;
                chg <= 1'b0;
                er  <= 1'b0;
            end else begin
                val <= val_next;
                chg <= (val_next != val);
                if ((MODE == 1) && illegal)
                    er <= 1'b1;
            end
        end

        assign value[i*WIDTH +: WIDTH] = val;
        assign changed[i]              = chg;
        assign err[i]                  = er;
    end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: four configurations share the same pins and are
// compared every cycle against a rotation-position reference model.
module tb_quad_encoder_bank;

    localparam int HL = 8;
    localparam int NK = 4;
    localparam int MODE_K [NK] = '{1, 0, 0, 0};
    localparam int STEP_K [NK] = '{1, 1, 16, 16};
    localparam int SAT_K  [NK] = '{0, 0, 0, 1};

    logic        clk;
    logic        reset;
    logic [2:0]  a_in;
    logic [2:0]  b_in;
    logic        load_en;
    logic [1:0]  load_ch;
    logic [7:0]  load_val;
    logic [23:0] v_o [NK];
    logic [2:0]  c_o [NK];
    logic [2:0]  e_o [NK];

    int tests = 0;
    int fails = 0;

    // reference model state
    int run_a [3];
    int run_b [3];
    bit last_a [3];
    bit last_b [3];
    int db_pos [3];
    int prev_pos [3];
    int raw_pos [3];
    int m_val [NK][3];
    bit m_chg [NK][3];
    bit m_err [NK][3];

    quad_encoder_bank #(.CHANNELS(3), .WIDTH(8), .HIST_LEN(HL), .MODE(1), .STEP(1), .SATURATE(0)) u_x4 (
        .clk(clk), .reset(reset), .a(a_in), .b(b_in), .load_en(load_en), .load_ch(load_ch),
        .load_val(load_val), .value(v_o[0]), .changed(c_o[0]), .err(e_o[0]));
    quad_encoder_bank #(.CHANNELS(3), .WIDTH(8), .HIST_LEN(HL), .MODE(0), .STEP(1), .SATURATE(0)) u_x1 (
        .clk(clk), .reset(reset), .a(a_in), .b(b_in), .load_en(load_en), .load_ch(load_ch),
        .load_val(load_val), .value(v_o[1]), .changed(c_o[1]), .err(e_o[1]));
    quad_encoder_bank #(.CHANNELS(3), .WIDTH(8), .HIST_LEN(HL), .MODE(0), .STEP(16), .SATURATE(0)) u_x1_s16w (
        .clk(clk), .reset(reset), .a(a_in), .b(b_in), .load_en(load_en), .load_ch(load_ch),
        .load_val(load_val), .value(v_o[2]), .changed(c_o[2]), .err(e_o[2]));
    quad_encoder_bank #(.CHANNELS(3), .WIDTH(8), .HIST_LEN(HL), .MODE(0), .STEP(16), .SATURATE(1)) u_x1_s16s (
        .clk(clk), .reset(reset), .a(a_in), .b(b_in), .load_en(load_en), .load_ch(load_ch),
        .load_val(load_val), .value(v_o[3]), .changed(c_o[3]), .err(e_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int posOf(bit av, bit bv);
        if (!av && !bv) return 0;
        if (av && !bv)  return 1;
        if (av && bv)   return 2;
        return 3;
    endfunction

    function automatic int stepVal(int k, int v, int dir);
        int nv;
        nv = (dir > 0) ? v + STEP_K[k] : v - STEP_K[k];
        if (SAT_K[k] != 0) begin
            if (nv > 255) nv = 255;
            if (nv < 0)   nv = 0;
        end else begin
            nv = (nv + 256) % 256;
        end
        return nv;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            run_a[c] = HL; run_b[c] = HL;
            last_a[c] = 1'b0; last_b[c] = 1'b0;
            db_pos[c] = 0; prev_pos[c] = 0;
            for (int k = 0; k < NK; k++) begin
                m_val[k][c] = 0; m_chg[k][c] = 1'b0; m_err[k][c] = 1'b0;
            end
        end
    endtask

    // One clock edge of the model: decode the last debounced move, then sample.
    task automatic modelStep();
        int d;
        int dir;
        int nv;
        bit db_a;
        bit db_b;
        for (int c = 0; c < 3; c++) begin
            d = (db_pos[c] - prev_pos[c] + 4) % 4;
            for (int k = 0; k < NK; k++) begin
                if (MODE_K[k] == 1)
                    dir = (d == 1) ? 1 : (d == 3) ? -1 : 0;
                else
                    dir = (d == 1 && db_pos[c] == 1) ? 1 : (d == 3 && db_pos[c] == 2) ? -1 : 0;
                nv = (dir != 0) ? stepVal(k, m_val[k][c], dir) : m_val[k][c];
                if (load_en && int'(load_ch) == c) begin
                    m_val[k][c] = int'(load_val);
                    m_chg[k][c] = 1'b0;
                    m_err[k][c] = 1'b0;
                end else begin
                    m_chg[k][c] = (nv != m_val[k][c]);
                    m_val[k][c] = nv;
                    if (MODE_K[k] == 1 && d == 2) m_err[k][c] = 1'b1;
                end
            end
            prev_pos[c] = db_pos[c];
            if (a_in[c] == last_a[c]) run_a[c] = (run_a[c] < HL) ? run_a[c] + 1 : HL;
            else begin last_a[c] = a_in[c]; run_a[c] = 1; end
            if (b_in[c] == last_b[c]) run_b[c] = (run_b[c] < HL) ? run_b[c] + 1 : HL;
            else begin last_b[c] = b_in[c]; run_b[c] = 1; end
            db_a = (db_pos[c] == 1 || db_pos[c] == 2);
            db_b = (db_pos[c] == 2 || db_pos[c] == 3);
            if (run_a[c] >= HL) db_a = last_a[c];
            if (run_b[c] >= HL) db_b = last_b[c];
            db_pos[c] = posOf(db_a, db_b);
        end
    endtask

    task automatic checkOutput(string tag);
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < 3; c++) begin
                tests++;
                assert (v_o[k][c*8 +: 8] === 8'(m_val[k][c])) else begin
                    fails++;
                    $error("FAIL %s value k%0d ch%0d: observed %0d expected %0d", tag, k, c, v_o[k][c*8 +: 8], m_val[k][c]);
                end
                tests++;
                assert (c_o[k][c] === m_chg[k][c]) else begin
                    fails++;
                    $error("FAIL %s changed k%0d ch%0d: observed %b expected %b", tag, k, c, c_o[k][c], m_chg[k][c]);
                end
                tests++;
                assert (e_o[k][c] === m_err[k][c]) else begin
                    fails++;
                    $error("FAIL %s err k%0d ch%0d: observed %b expected %b", tag, k, c, e_o[k][c], m_err[k][c]);
                end
            end
        end
    endtask

    task automatic checkConst(string tag, logic [31:0] observed, logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (!reset) modelReset();
        else        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic setPhase(int c, int p);
        a_in[c] = (p == 1 || p == 2);
        b_in[c] = (p == 2 || p == 3);
        raw_pos[c] = p;
    endtask

    task automatic applyStimulus(int c, int p, int cycles, string tag);
        setPhase(c, p);
        repeat (cycles) tick(tag);
    endtask

    task automatic doLoad(int ch, int val, string tag);
        load_en = 1'b1; load_ch = 2'(ch); load_val = 8'(val);
        tick(tag);
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; a_in = '0; b_in = '0;
        load_en = 1'b0; load_ch = '0; load_val = '0;
        for (int c = 0; c < 3; c++) raw_pos[c] = 0;
        modelReset();
        #2 reset = 1'b0;
        #1 checkOutput("reset");
        tick("reset_hold");
        tick("reset_hold");
        reset = 1'b1;
        repeat (12) tick("idle");

        // forward detent on ch0 with explicit pulse timing on the first phase
        setPhase(0, 1);
        repeat (HL) tick("fwd_lat");
        checkConst("fwd_no_pulse_yet", 32'(c_o[0][0]), 0);
        tick("fwd_lat");
        checkConst("fwd_pulse_at_hl_plus1", 32'(c_o[0][0]), 1);
        repeat (3) tick("fwd");
        applyStimulus(0, 2, 12, "fwd");
        applyStimulus(0, 3, 12, "fwd");
        applyStimulus(0, 0, 12, "fwd");
        checkConst("fwd_x4_ch0", 32'(v_o[0][7:0]), 4);
        checkConst("fwd_x1_ch0", 32'(v_o[1][7:0]), 1);
        checkConst("fwd_s16_ch0", 32'(v_o[2][7:0]), 16);

        applyStimulus(0, 3, 12, "rev");
        applyStimulus(0, 2, 12, "rev");
        applyStimulus(0, 1, 12, "rev");
        applyStimulus(0, 0, 12, "rev");
        checkConst("rev_x4_ch0", 32'(v_o[0][7:0]), 0);
        checkConst("rev_x1_ch0", 32'(v_o[1][7:0]), 0);

        // one reverse detent on ch1 from zero: wrap vs saturate
        applyStimulus(1, 3, 12, "underflow");
        applyStimulus(1, 2, 12, "underflow");
        applyStimulus(1, 1, 12, "underflow");
        applyStimulus(1, 0, 12, "underflow");
        checkConst("under_x4_ch1", 32'(v_o[0][15:8]), 252);
        checkConst("under_x1_ch1", 32'(v_o[1][15:8]), 255);
        checkConst("under_s16w_ch1", 32'(v_o[2][15:8]), 240);
        checkConst("under_s16s_ch1", 32'(v_o[3][15:8]), 0);

        // forward detent from 250
        doLoad(1, 250, "preload");
        repeat (3) tick("preload");
        applyStimulus(1, 1, 12, "overflow");
        applyStimulus(1, 2, 12, "overflow");
        applyStimulus(1, 3, 12, "overflow");
        applyStimulus(1, 0, 12, "overflow");
        checkConst("over_x4_ch1", 32'(v_o[0][15:8]), 254);
        checkConst("over_s16w_ch1", 32'(v_o[2][15:8]), 10);
        checkConst("over_s16s_ch1", 32'(v_o[3][15:8]), 255);

        // short glitch on a[2] must not reach the decoder
        applyStimulus(2, 1, 3, "glitch");
        applyStimulus(2, 0, 14, "glitch");
        checkConst("glitch_x4_ch2", 32'(v_o[0][23:16]), 0);

        // both phases flip at once
        applyStimulus(2, 2, 12, "illegal");
        checkConst("illegal_err_x4", 32'(e_o[0][2]), 1);
        checkConst("illegal_err_x1", 32'(e_o[1][2]), 0);
        checkConst("illegal_val_x4", 32'(v_o[0][23:16]), 0);
        doLoad(2, 8'h80, "err_clear");
        checkConst("clear_err_x4", 32'(e_o[0][2]), 0);
        checkConst("clear_val_x4", 32'(v_o[0][23:16]), 128);
        applyStimulus(2, 1, 12, "illegal_back");

        // load on ch0 collides with a count on ch0 while ch1 also counts
        setPhase(0, 1);
        setPhase(1, 1);
        repeat (HL) tick("collide");
        doLoad(0, 8'h33, "collide");
        checkConst("collide_ch0_val", 32'(v_o[0][7:0]), 32'h33);
        checkConst("collide_ch0_pulse", 32'(c_o[0][0]), 0);
        checkConst("collide_ch1_pulse", 32'(c_o[0][1]), 1);
        checkConst("collide_ch1_val", 32'(v_o[0][15:8]), 255);
        repeat (4) tick("collide");
        doLoad(3, 8'hAA, "bad_ch");
        repeat (2) tick("bad_ch");

        // reset in the middle of a rotation
        setPhase(0, 2);
        repeat (HL + 3) tick("mid_reset");
        #2 reset = 1'b0;
        #1 modelReset();
        checkOutput("mid_reset_async");
        checkConst("mid_reset_val", 32'(v_o[0][7:0]), 0);
        @(negedge clk);
        tick("mid_reset_hold");
        reset = 1'b1;
        repeat (12) tick("after_reset");

        // randomized rotation, glitches, illegal jumps and loads
        for (int n = 0; n < 350; n++) begin
            int sel;
            int c;
            sel = int'($urandom_range(0, 11));
            c = int'($urandom_range(0, 2));
            if (sel <= 5)
                setPhase(c, (raw_pos[c] + 1) % 4);
            else if (sel <= 8)
                setPhase(c, (raw_pos[c] + 3) % 4);
            else if (sel == 9)
                setPhase(c, (raw_pos[c] + 2) % 4);
            else if (sel == 10)
                for (int j = 0; j < 3; j++) setPhase(j, (raw_pos[j] + 1) % 4);
            if (sel == 11) begin
                load_en = 1'b1;
                load_ch = 2'($urandom_range(0, 3));
                load_val = 8'($urandom);
            end
            tick("random");
            load_en = 1'b0;
            repeat ($urandom_range(0, 13)) tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
